// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation encodings, FSM states
// and the alignment rules used by the check stage.
package lsu_pkg;

  localparam int MEM_LAT_MAX = 4;
  // Wide enough to count RD cycles 0..MEM_LAT_MAX-1
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } lsu_state_e;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         is_misaligned = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(lsu_op_e op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Combinational lane handling: extracts and extends the addressed byte or
// halfword of a read word for loads, and merges store data into the addressed
// lane(s) of a read word for sub-word stores. Lanes are little-endian.
module ls_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  lsu_op_e     op_e;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign op_e   = lsu_op_e'(op);
  assign lane_b = rdata[{byte_off, 3'b000} +: 8];
  assign lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];

  // Select the addressed lane and sign- or zero-extend it to 32 bits
  always_comb begin
    load_ext = rdata;
    case (op_e)
      OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_ext = {16'h0000, lane_h};
      OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_ext = {24'h000000, lane_b};
      default: load_ext = rdata;
    endcase
  end

  // Each byte lane independently decides whether it takes store data or
  // keeps the byte that was read back from memory
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       hit;
    logic [7:0] src;

    // Lane hit and source byte for the current store type
    always_comb begin
      hit = 1'b0;
      src = store_data[7:0];
      case (op_e)
        OP_SW: begin
          hit = 1'b1;
          src = store_data[8*gi +: 8];
        end
        OP_SH: begin
          hit = (byte_off[1] == LANE[1]);
          src = store_data[8*(gi%2) +: 8];
        end
        OP_SB: hit = (byte_off == LANE);
        default: hit = 1'b0;
      endcase
    end

    assign merged[8*gi +: 8] = hit ? src : rdata[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine between the control FSM and a word-addressed
// data memory. One access per start pulse; sub-word stores are done as a
// read-modify-write of the containing word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1  // read latency in cycles, legal 1..MEM_LAT_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  lsu_state_e       state_q;
  lsu_op_e          op_q;
  logic [31:0]      addr_q;
  logic [31:0]      sdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data_q;
  logic             addr_err_q;

  logic [31:0]      load_data_d;
  logic [31:0]      wdata_d;

  // Lane logic works on the live memory word so the read data is consumed
  // on the same edge that ends the RD phase
  ls_lane_align u_align (
    .op         (op_q),
    .byte_off   (addr_q[1:0]),
    .rdata      (mem_rdata),
    .store_data (sdata_q),
    .load_ext   (load_data_d),
    .merged     (wdata_d)
  );

  // Control FSM with latency counter, operand latches and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      addr_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q       <= lsu_op_e'(op);
            addr_q     <= addr;
            sdata_q    <= store_data;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (is_misaligned(op_q, addr_q[1:0])) begin
            addr_err_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else if (op_q == OP_SW) begin
            // Full-word store needs no read; merge passes store data through
            wr_q    <= 1'b1;
            wdata_q <= wdata_d;
            state_q <= ST_WR;
          end else begin
            cnt_q   <= '0;
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          if (cnt_q == CNT_LAST) begin
            if (is_store(op_q)) begin
              wr_q    <= 1'b1;
              wdata_q <= wdata_d;
              state_q <= ST_WR;
            end else begin
              load_data_q <= load_data_d;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  // A write still pending when reset is pulled low must not reach memory
  // on the reset edge, so the strobe is qualified by reset as well
  assign mem_wr    = wr_q & reset;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign load_data = load_data_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each attached to its own behavioural memory.
module tb_load_store_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wd;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_init;
  logic [2:0]  op_s;
  logic [31:0] addr_s, sdata_s;
  logic        start0, start1;
  logic [31:0] rdata0, rdata1, maddr0, maddr1, wdata0, wdata1, ld0, ld1;
  logic        wr0, wr1, busy0, busy1, done0, done1, err0, err1;

  load_store_unit #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start0), .op(op_s), .addr(addr_s),
    .store_data(sdata_s), .mem_rdata(rdata0), .mem_addr(maddr0), .mem_wr(wr0),
    .mem_wdata(wdata0), .busy(busy0), .done(done0), .load_data(ld0), .addr_err(err0)
  );

  load_store_unit #(.MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start1), .op(op_s), .addr(addr_s),
    .store_data(sdata_s), .mem_rdata(rdata1), .mem_addr(maddr1), .mem_wr(wr1),
    .mem_wdata(wdata1), .busy(busy1), .done(done1), .load_data(ld1), .addr_err(err1)
  );

  // Behavioural memories: word 0x40 is byte address 0x100
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] pipe1 [0:1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'h0;
        mem1[i] <= 32'h0;
      end
      mem0[8'h40] <= 32'h8899AABB;
      mem1[8'h40] <= 32'h8899AABB;
      mem0[8'h41] <= 32'h11223344;
      mem1[8'h41] <= 32'h11223344;
    end else begin
      if (wr0) mem0[maddr0[9:2]] <= wdata0;
      if (wr1) mem1[maddr1[9:2]] <= wdata1;
    end
    rdata0   <= mem0[maddr0[9:2]];
    pipe1[0] <= mem1[maddr1[9:2]];
    pipe1[1] <= pipe1[0];
    rdata1   <= pipe1[1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  int wrc0 = 0, wrc1 = 0;
  logic [31:0] wdl0 = 32'h0, wdl1 = 32'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic check_txn(string tag, exp_t e, logic [31:0] ld, logic err,
                           logic bsy, int lat, int nwr, logic [31:0] wdl);
    chk($sformatf("%s %s load_data", tag, e.name), ld, e.ld);
    chk($sformatf("%s %s addr_err", tag, e.name), {31'h0, err}, {31'h0, e.err});
    chk($sformatf("%s %s latency", tag, e.name), lat, e.lat);
    chk($sformatf("%s %s mem_wr count", tag, e.name), nwr, e.nwr);
    chk($sformatf("%s %s busy at done", tag, e.name), {31'h0, bsy}, 32'h1);
    if (e.nwr > 0) chk($sformatf("%s %s wdata", tag, e.name), wdl, e.wd);
    $display("[TB] %s %s: load_data=%h addr_err=%0d latency=%0d writes=%0d wdata=%h",
             tag, e.name, ld, err, lat, nwr, wdl);
  endtask

  // Monitor: counts write strobes and checks each done against the queue
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr0 === 1'b1) begin wrc0++; wdl0 = wdata0; end
      if (wr1 === 1'b1) begin wrc1++; wdl1 = wdata1; end
      if (done0 === 1'b1) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL L1 spurious done: got done=1 required no pending request");
        end else begin
          e = q0.pop_front();
          check_txn("L1", e, ld0, err0, busy0, cyc - e.t0, wrc0, wdl0);
        end
        wrc0 = 0;
      end
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL L3 spurious done: got done=1 required no pending request");
        end else begin
          e = q1.pop_front();
          check_txn("L3", e, ld1, err1, busy1, cyc - e.t0, wrc1, wdl1);
        end
        wrc1 = 0;
      end
    end
  end

  // Drive one start pulse; optionally record the expected response
  task automatic issue(int k, logic [2:0] o, logic [31:0] a, logic [31:0] d,
                       string nm, logic [31:0] ld, logic err, int lat, int nwr,
                       logic [31:0] wd, bit push);
    exp_t e;
    @(posedge clk); #1;
    op_s = o; addr_s = a; sdata_s = d;
    if (k == 0) start0 = 1'b1; else start1 = 1'b1;
    e.name = nm; e.ld = ld; e.err = err; e.lat = lat; e.nwr = nwr; e.wd = wd;
    e.t0 = cyc;
    if (push) begin
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Wait until all expected responses for instance k have been seen
  task automatic wait_idle(int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if ((k == 0 ? q0.size() : q1.size()) == 0) return;
    end
    n_tests++; n_fail++;
    $display("FAIL timeout L%0d: got %0d pending required 0", (k == 0) ? 1 : 3,
             (k == 0) ? q0.size() : q1.size());
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic run(int k, logic [2:0] o, logic [31:0] a, logic [31:0] d, string nm,
                     logic [31:0] ld, logic err, int lat, int nwr, logic [31:0] wd);
    issue(k, o, a, d, nm, ld, err, lat, nwr, wd, 1'b1);
    wait_idle(k);
  endtask

  initial begin
    reset = 1'b0; mem_init = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    op_s = 3'd0; addr_s = 32'h0; sdata_s = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy",      {30'h0, busy0, busy1}, 32'h0);
    chk("reset done",      {30'h0, done0, done1}, 32'h0);
    chk("reset mem_wr",    {30'h0, wr0, wr1}, 32'h0);
    chk("reset addr_err",  {30'h0, err0, err1}, 32'h0);
    chk("reset load_data", ld0 | ld1, 32'h0);
    chk("reset mem_addr",  maddr0 | maddr1, 32'h0);
    chk("reset mem_wdata", wdata0 | wdata1, 32'h0);
    $display("[TB] reset state checked");
    reset = 1'b1; mem_init = 1'b0;

    // MEM_LAT=1 loads
    run(0, LW,  32'h100, 32'h0, "LW 0x100",  32'h8899AABB, 1'b0, 3, 0, 32'h0);
    run(0, LB,  32'h103, 32'h0, "LB 0x103",  32'hFFFFFF88, 1'b0, 3, 0, 32'h0);
    run(0, LBU, 32'h101, 32'h0, "LBU 0x101", 32'h000000AA, 1'b0, 3, 0, 32'h0);
    run(0, LH,  32'h102, 32'h0, "LH 0x102",  32'hFFFF8899, 1'b0, 3, 0, 32'h0);
    run(0, LHU, 32'h100, 32'h0, "LHU 0x100", 32'h0000AABB, 1'b0, 3, 0, 32'h0);
    // Stores
    run(0, SB,  32'h102, 32'h12345677, "SB 0x102", 32'h0000AABB, 1'b0, 4, 1, 32'h8877AABB);
    run(0, LW,  32'h100, 32'h0, "LW after SB", 32'h8877AABB, 1'b0, 3, 0, 32'h0);
    run(0, SW,  32'h100, 32'hDEADBEEF, "SW 0x100", 32'h8877AABB, 1'b0, 3, 1, 32'hDEADBEEF);
    // Misaligned accesses, then an aligned one clears the flag
    run(0, LH,  32'h101, 32'h0, "LH 0x101 misaligned", 32'h8877AABB, 1'b1, 2, 0, 32'h0);
    run(0, SW,  32'h102, 32'h55, "SW 0x102 misaligned", 32'h8877AABB, 1'b1, 2, 0, 32'h0);
    run(0, LBU, 32'h100, 32'h0, "LBU 0x100", 32'h000000EF, 1'b0, 3, 0, 32'h0);

    // start while busy is ignored
    issue(0, LB, 32'h100, 32'h0, "LB busy-start", 32'hFFFFFFEF, 1'b0, 3, 0, 32'h0, 1'b1);
    chk("busy during CHK", {31'h0, busy0}, 32'h1);
    op_s = SW; addr_s = 32'h200; sdata_s = 32'hFFFFFFFF; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    wait_idle(0);
    repeat (8) @(negedge clk);
    chk("ignored start writes", wrc0, 0);

    // Reset asserted during the WR cycle of SH
    issue(0, SH, 32'h104, 32'h0000CAFE, "SH reset", 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post-reset busy", {31'h0, busy0}, 32'h0);
    chk("post-reset done", {31'h0, done0}, 32'h0);
    chk("post-reset load_data", ld0, 32'h0);
    chk("post-reset mem_wr", {31'h0, wr0}, 32'h0);
    repeat (4) @(negedge clk);
    chk("aborted SH writes", wrc0, 0);
    chk("aborted SH memory", mem0[8'h41], 32'h11223344);
    $display("[TB] L1 SH aborted by reset: writes=%0d mem=%h", wrc0, mem0[8'h41]);
    wrc0 = 0;
    run(0, LH,  32'h106, 32'h0, "LH 0x106", 32'h00001122, 1'b0, 3, 0, 32'h0);
    run(0, SH,  32'h106, 32'h0000CAFE, "SH 0x106", 32'h00001122, 1'b0, 4, 1, 32'hCAFE3344);
    run(0, LH,  32'h106, 32'h0, "LH after SH", 32'hFFFFCAFE, 1'b0, 3, 0, 32'h0);

    // MEM_LAT=3, each request issued in the cycle after the previous done
    run(1, LW,  32'h100, 32'h0, "LW 0x100", 32'h8899AABB, 1'b0, 5, 0, 32'h0);
    run(1, SB,  32'h100, 32'h00000055, "SB 0x100", 32'h8899AABB, 1'b0, 6, 1, 32'h8899AA55);
    run(1, LBU, 32'h100, 32'h0, "LBU 0x100", 32'h00000055, 1'b0, 5, 0, 32'h0);
    run(1, LH,  32'h102, 32'h0, "LH 0x102", 32'hFFFF8899, 1'b0, 5, 0, 32'h0);
    run(1, SW,  32'h104, 32'h01020304, "SW 0x104", 32'hFFFF8899, 1'b0, 3, 1, 32'h01020304);
    run(1, LW,  32'h104, 32'h0, "LW 0x104", 32'h01020304, 1'b0, 5, 0, 32'h0);

    repeat (4) @(negedge clk);
    chk("pending responses", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
